multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  IR[6:0], stable from the cycle after ir_write until the next ir_write.
REQ-005 funct3  input  3  IR[14:12].
REQ-006 funct7  input  7  IR[31:25].
REQ-007 zero  input  1  ALU zero flag, same cycle.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 pc_write, ir_write, reg_write, mem_read, mem_write  output  1 each  datapath strobes.
REQ-010 iord  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 alu_src_a  output  1  ALU A select: 0=PC, 1=rs1.
REQ-012 alu_src_b  output  2  ALU B select: 00=rs2, 01=constant 4, 10=immediate.
REQ-013 alu_op  output  2  to ALU control: 00=add, 01=subtract, 10=funct-decoded.
REQ-014 mem_to_reg, pc_src  output  1 each  writeback select (1=MDR); PC select (1=ALUOut).
REQ-015 state  output  4  current state encoding.
REQ-016 illegal  output  1  unsupported instruction trapped.
REQ-017 instr_count  output  16  retired instruction count.

Function
REQ-018 Encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_MEM=8, WB_ALU=9, BRANCH=10, ILLEGAL=11.
REQ-019 Outputs are combinational from state (plus mem_ready/zero where stated); any output not listed for a state is 0.
REQ-020 IDLE: all strobes 0; next state FETCH unconditionally.
REQ-021 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00; pc_write=ir_write=mem_ready; stays until mem_ready=1, then DECODE.
REQ-022 DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target precompute); next state from opcode/funct3/funct7 per REQ-023.
REQ-023 Decode: 0000011+f3 000 (lb) or 0100011+f3 000 (sb) -> MEM_ADDR; 0110011 with f3 000/111/001 and f7 0000000 -> EXEC_R; 0010011+f3 110 -> EXEC_I; 1100011+f3 001 -> BRANCH; all else -> ILLEGAL.
REQ-024 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next WB_ALU.
REQ-025 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=10; next WB_ALU.
REQ-026 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD if opcode=0000011, else MEM_WR.
REQ-027 MEM_RD: mem_read=1, iord=1; hold until mem_ready, then WB_MEM.
REQ-028 MEM_WR: mem_write=1, iord=1; hold until mem_ready, then FETCH (retire).
REQ-029 WB_MEM: reg_write=1, mem_to_reg=1; WB_ALU: reg_write=1, mem_to_reg=0; both next FETCH (retire).
REQ-030 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=~zero; next FETCH (retire).
REQ-031 ILLEGAL: illegal=1, all strobes 0; sticky until reset.
REQ-032 instr_count increments by 1 on each retire transition; wraps 0xFFFF -> 0x0000.
REQ-033 Latency with mem_ready always 1, FETCH entry to next FETCH entry: R-type/ori 4 cycles, lb 5, sb 4, bne 3; each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds one.

Reset
REQ-034 reset=1 at a clock edge forces state=IDLE and instr_count=0, overriding any transition, including mid-instruction and during a memory wait.
REQ-035 During and after reset, in IDLE, all 1-bit outputs=0, alu_src_b=00, alu_op=00, illegal=0.

Verification
REQ-036 Reset, add (0110011/000/0000000), mem_ready=1 -> states 1,2,3,9,1; reg_write high in one cycle only; instr_count=1.
REQ-037 lb with mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_read=iord=1 throughout, then WB_MEM with mem_to_reg=1.
REQ-038 bne with zero=0 -> pc_write=1, pc_src=1 in BRANCH; with zero=1 -> pc_write=0; both retire.
REQ-039 opcode 0110011, f3 010 -> ILLEGAL, illegal=1 held 10 cycles, instr_count unchanged; reset -> IDLE, illegal=0.
REQ-040 reset asserted in MEM_WR while mem_ready=0 -> next cycle IDLE, mem_write=0, instr_count=0.
REQ-041 0xFFFF retirements, then one more -> instr_count=0x0000.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle controller: instruction fields and
// flags in, datapath strobes and status out.
interface multicycle_control_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        mem_to_reg;
  logic        pc_src;
  logic [3:0]  state;
  logic        illegal;
  logic [15:0] instr_count;

  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, iord,
           alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_src, state,
           illegal, instr_count
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, iord,
           alu_src_a, alu_src_b, alu_op, mem_to_reg, pc_src, state,
           illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V subset controller: Moore-style FSM sequencing fetch, decode,
// execute, memory and writeback, with a retired-instruction counter.
module multicycle_control (
  input  logic                  clock,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_MEM   = 4'd8,
    WB_ALU   = 4'd9,
    BRANCH   = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  state_t      decoded;
  logic        retire;
  logic [15:0] count;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset)       count <= '0;
    else if (retire) count <= count + 16'd1;
  end

  always_comb begin
    decoded = ILLEGAL;
    if ((bus.opcode == 7'b0000011 || bus.opcode == 7'b0100011) && bus.funct3 == 3'b000)
      decoded = MEM_ADDR;
    else if (bus.opcode == 7'b0110011 && bus.funct7 == 7'b0000000 &&
             (bus.funct3 == 3'b000 || bus.funct3 == 3'b111 || bus.funct3 == 3'b001))
      decoded = EXEC_R;
    else if (bus.opcode == 7'b0010011 && bus.funct3 == 3'b110)
      decoded = EXEC_I;
    else if (bus.opcode == 7'b1100011 && bus.funct3 == 3'b001)
      decoded = BRANCH;
  end

  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.mem_to_reg = 1'b0;
    bus.pc_src     = 1'b0;
    bus.illegal    = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.pc_write  = bus.mem_ready;
        bus.ir_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // ALU computes PC + imm here so the branch target is ready in ALUOut
        bus.alu_src_b = 2'b10;
        state_d       = decoded;
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = WB_ALU;
      end
      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b10;
        state_d       = WB_ALU;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == 7'b0000011) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = WB_MEM;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = FETCH;
        retire         = 1'b1;
      end
      WB_ALU: begin
        bus.reg_write = 1'b1;
        state_d       = FETCH;
        retire        = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 1'b1;
        bus.pc_write  = ~bus.zero;
        state_d       = FETCH;
        retire        = 1'b1;
      end
      ILLEGAL: bus.illegal = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.instr_count = count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences push
// per-cycle expectations; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [3:0] S_IDL = 4'd0,  S_FET = 4'd1,  S_DEC = 4'd2,  S_EXR = 4'd3,
                         S_EXI = 4'd4,  S_MA  = 4'd5,  S_MRD = 4'd6,  S_MWR = 4'd7,
                         S_WBM = 4'd8,  S_WBA = 4'd9,  S_BR  = 4'd10, S_ILL = 4'd11;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_to_reg;
    logic       pc_src;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic [3:0]  st;
    outs_t       o;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [15:0] cnt_model = '0;

  function automatic outs_t table_outs(input logic [3:0] st, input logic mr, input logic z);
    outs_t o;
    o = '0;
    case (st)
      S_FET: begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.pc_write = mr; o.ir_write = mr; end
      S_DEC: o.alu_src_b = 2'b10;
      S_EXR: begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      S_EXI: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b10; end
      S_MA:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      S_MRD: begin o.mem_read = 1'b1; o.iord = 1'b1; end
      S_MWR: begin o.mem_write = 1'b1; o.iord = 1'b1; end
      S_WBM: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      S_WBA: o.reg_write = 1'b1;
      S_BR:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_src = 1'b1; o.pc_write = ~z; end
      S_ILL: o.illegal = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic cyc(input logic [3:0] st, input logic mr, input logic z,
                     input logic rst, input logic ret, input string nm);
    exp_t e;
    reset         = rst;
    bus.mem_ready = mr;
    bus.zero      = z;
    e.st  = st;
    e.o   = table_outs(st, mr, z);
    e.cnt = cnt_model;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
    if (rst)      cnt_model = '0;
    else if (ret) cnt_model = cnt_model + 16'd1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  exp_t  mon_e;
  exp_t  mon_a;
  string mon_nm;
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      mon_a.st = bus.state;
      mon_a.o  = '{bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write,
                   bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.mem_to_reg,
                   bus.pc_src, bus.illegal};
      mon_a.cnt = bus.instr_count;
      total++;
      if (mon_a === mon_e) passed++;
      else $display("FAIL %s: got state=%0d outs=%h count=%h, expected state=%0d outs=%h count=%h",
                    mon_nm, mon_a.st, mon_a.o, mon_a.cnt, mon_e.st, mon_e.o, mon_e.cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.funct7    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clock);
    #1;
    cyc(S_IDL, 1, 0, 1, 0, "reset_hold");
    cyc(S_IDL, 1, 0, 0, 0, "idle");

    set_ir(7'b0110011, 3'b000, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "add_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "add_decode");
    cyc(S_EXR, 1, 0, 0, 0, "add_exec");
    cyc(S_WBA, 1, 0, 0, 1, "add_wb");
    total++;
    if (bus.instr_count === 16'd1) passed++;
    else $display("FAIL add_retire_count: got %h, expected 0001", bus.instr_count);
    total++;
    if (bus.state === S_FET) passed++;
    else $display("FAIL add_next_fetch: got state=%0d, expected %0d", bus.state, S_FET);

    set_ir(7'b0010011, 3'b110, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "ori_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "ori_decode");
    cyc(S_EXI, 1, 0, 0, 0, "ori_exec");
    cyc(S_WBA, 1, 0, 0, 1, "ori_wb");

    set_ir(7'b0000011, 3'b000, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "lb_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "lb_decode");
    cyc(S_MA,  1, 0, 0, 0, "lb_addr");
    cyc(S_MRD, 0, 0, 0, 0, "lb_rd_wait1");
    cyc(S_MRD, 0, 0, 0, 0, "lb_rd_wait2");
    cyc(S_MRD, 1, 0, 0, 0, "lb_rd_done");
    cyc(S_WBM, 1, 0, 0, 1, "lb_wb");

    set_ir(7'b0100011, 3'b000, 7'b0000000);
    cyc(S_FET, 0, 0, 0, 0, "sb_fetch_wait");
    cyc(S_FET, 1, 0, 0, 0, "sb_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "sb_decode");
    cyc(S_MA,  1, 0, 0, 0, "sb_addr");
    cyc(S_MWR, 1, 0, 0, 1, "sb_wr");

    set_ir(7'b1100011, 3'b001, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "bne0_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "bne0_decode");
    cyc(S_BR,  1, 0, 0, 1, "bne_zero0");
    cyc(S_FET, 1, 1, 0, 0, "bne1_fetch");
    cyc(S_DEC, 1, 1, 0, 0, "bne1_decode");
    cyc(S_BR,  1, 1, 0, 1, "bne_zero1");

    set_ir(7'b0110011, 3'b111, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "and_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "and_decode");
    cyc(S_EXR, 1, 0, 0, 0, "and_exec");
    cyc(S_WBA, 1, 0, 0, 1, "and_wb");
    set_ir(7'b0110011, 3'b001, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "sll_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "sll_decode");
    cyc(S_EXR, 1, 0, 0, 0, "sll_exec");
    cyc(S_WBA, 1, 0, 0, 1, "sll_wb");

    set_ir(7'b0110011, 3'b010, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "slt_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "slt_decode");
    for (int unsigned i = 0; i < 10; i++) cyc(S_ILL, 1, 0, 0, 0, "slt_illegal_hold");
    total++;
    if (bus.illegal === 1'b1) passed++;
    else $display("FAIL slt_illegal_sticky: got %b, expected 1", bus.illegal);
    total++;
    if (bus.instr_count === 16'd8) passed++;
    else $display("FAIL slt_count_frozen: got %h, expected 0008", bus.instr_count);
    cyc(S_ILL, 1, 0, 1, 0, "illegal_reset_edge");
    cyc(S_IDL, 1, 0, 0, 0, "illegal_cleared");

    set_ir(7'b0110011, 3'b000, 7'b0100000);
    cyc(S_FET, 1, 0, 0, 0, "sub_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "sub_decode");
    cyc(S_ILL, 1, 0, 0, 0, "sub_illegal");
    cyc(S_ILL, 1, 0, 1, 0, "sub_reset_edge");
    cyc(S_IDL, 1, 0, 0, 0, "sub_cleared");

    set_ir(7'b0110011, 3'b000, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "add2_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "add2_decode");
    cyc(S_EXR, 1, 0, 0, 0, "add2_exec");
    cyc(S_WBA, 1, 0, 0, 1, "add2_wb");
    set_ir(7'b0100011, 3'b000, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "sb2_fetch");
    cyc(S_DEC, 1, 0, 0, 0, "sb2_decode");
    cyc(S_MA,  1, 0, 0, 0, "sb2_addr");
    cyc(S_MWR, 0, 0, 0, 0, "sb2_wr_wait");
    cyc(S_MWR, 0, 0, 1, 0, "sb2_reset_edge");
    total++;
    if (bus.mem_write === 1'b0) passed++;
    else $display("FAIL sb2_reset_mem_write: got %b, expected 0", bus.mem_write);
    total++;
    if (bus.instr_count === 16'd0) passed++;
    else $display("FAIL sb2_reset_count: got %h, expected 0000", bus.instr_count);
    cyc(S_IDL, 0, 0, 0, 0, "sb2_reset_idle");

    force dut.count = 16'hFFFE;
    cnt_model = 16'hFFFE;
    #1;
    release dut.count;
    set_ir(7'b1100011, 3'b001, 7'b0000000);
    cyc(S_FET, 1, 0, 0, 0, "wrap_fetch_a");
    cyc(S_DEC, 1, 0, 0, 0, "wrap_decode_a");
    cyc(S_BR,  1, 0, 0, 1, "wrap_branch_a");
    cyc(S_FET, 1, 0, 0, 0, "wrap_fetch_b");
    cyc(S_DEC, 1, 0, 0, 0, "wrap_decode_b");
    cyc(S_BR,  1, 0, 0, 1, "wrap_branch_b");
    cyc(S_FET, 1, 0, 0, 0, "wrap_zero");
    total++;
    if (bus.instr_count === 16'h0000) passed++;
    else $display("FAIL wrap_count: got %h, expected 0000", bus.instr_count);
    total++;
    if (bus.state === S_DEC) passed++;
    else $display("FAIL wrap_next_state: got state=%0d, expected %0d", bus.state, S_DEC);

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
